// File: rtl/mem_access_stage.sv
// Memory stage of the five-stage pipeline: issues load/store requests on a
// req/ack data-memory port, stalls upstream while waiting, and fills M/WB.
module mem_access_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] address_in,
    input  logic [31:0] data_in,
    input  logic [3:0]  control_in,
    input  logic [4:0]  rgD_index_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rgD_index,
    output logic        align_fault,
    output logic        bus_err
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;

    logic mem_read;
    logic mem_write;
    logic reg_write_req;
    logic byte_access;
    logic memop;
    logic misaligned;
    logic issue;
    logic req_c;
    logic stall_c;
    logic [31:0] load_value;

    function automatic logic [3:0] byte_enables(input logic is_byte, input logic [1:0] lane);
        byte_enables = is_byte ? (4'b0001 << lane) : 4'b1111;
    endfunction

    // Byte loads return the addressed lane zero-extended; word loads pass through.
    function automatic logic [31:0] load_result(input logic is_byte, input logic [1:0] lane,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        shifted = rdata >> {lane, 3'b000};
        load_result = is_byte ? {24'd0, shifted[7:0]} : rdata;
    endfunction

    assign mem_read      = control_in[0];
    assign mem_write     = control_in[1];
    assign reg_write_req = control_in[2];
    assign byte_access   = control_in[3];
    assign memop         = valid_in & (mem_read | mem_write);
    assign misaligned    = memop & ~byte_access & (address_in[1:0] != 2'b00);
    assign issue         = memop & ~misaligned;
    assign load_value    = load_result(byte_access, address_in[1:0], mem_rdata);

    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_c = issue;
                if (issue && !mem_ack) begin
                    stall_c    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (mem_ack || wait_cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held.
    assign mem_req   = req_c & reset;
    assign stall     = stall_c & reset;
    assign mem_we    = mem_req & mem_write;
    assign mem_be    = mem_req ? byte_enables(byte_access, address_in[1:0]) : 4'b0000;
    assign mem_addr  = {address_in[31:2], 2'b00};
    assign mem_wdata = byte_access ? {4{data_in[7:0]}} : data_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            wb_rgD_index <= 5'd0;
            align_fault  <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            align_fault <= 1'b0;
            bus_err     <= 1'b0;
            if (stall_c) begin
                wb_valid <= 1'b0;
            end else if (state == ST_WAIT) begin
                // Leaving WAIT: either the ack arrived or the wait timed out.
                wb_valid     <= 1'b1;
                wb_rgD_index <= rgD_index_in;
                if (mem_ack) begin
                    wb_reg_write <= reg_write_req & ~mem_write;
                    wb_data      <= mem_write ? address_in : load_value;
                end else begin
                    wb_reg_write <= 1'b0;
                    wb_data      <= address_in;
                    bus_err      <= 1'b1;
                end
            end else begin
                wb_valid     <= valid_in;
                wb_rgD_index <= rgD_index_in;
                if (misaligned) begin
                    wb_reg_write <= 1'b0;
                    wb_data      <= address_in;
                    align_fault  <= 1'b1;
                end else if (issue) begin
                    wb_reg_write <= reg_write_req & ~mem_write;
                    wb_data      <= mem_write ? address_in : load_value;
                end else begin
                    wb_reg_write <= reg_write_req & valid_in;
                    wb_data      <= address_in;
                end
            end
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage pipeline. It sits directly downstream of the EX/M pipeline register and consumes its address, store data, control and destination-register outputs. It performs load/store transactions on the data-memory port with a req/ack handshake and stalls upstream while a transaction is outstanding. Results are registered into the M/WB stage outputs for the writeback stage.

## Interface
Parameters:
- TIMEOUT, 64: maximum number of cycles spent waiting for mem_ack before the access is aborted. Legal range is 2..255.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  EX/M holds a valid instruction
- address_in  in  32  ALU result; memory address for loads/stores, result value otherwise
- data_in  in  32  store data
- control_in  in  4  bit0 mem_read, bit1 mem_write, bit2 reg_write, bit3 byte access
- rgD_index_in  in  5  destination register index
- stall  out  1  upstream must hold EX/M (write = ~stall)
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address ({address_in[31:2],2'b00})
- mem_wdata  out  32  store data, lane-replicated for byte stores
- mem_be  out  4  byte enables
- mem_rdata  in  32  load data, valid when mem_ack is high
- mem_ack  in  1  transaction complete; single-cycle pulse
- wb_valid  out  1  M/WB holds a valid instruction
- wb_reg_write  out  1  write wb_data to register wb_rgD_index
- wb_data  out  32  load result or passed-through address_in
- wb_rgD_index  out  5  destination register index
- align_fault  out  1  one-cycle pulse: misaligned word access dropped
- bus_err  out  1  one-cycle pulse: access aborted by timeout

## Operation
- FSM states: IDLE and WAIT. A "memop" is valid_in & (mem_read | mem_write). If mem_read and mem_write are both set, the access is treated as a store.
- Non-memop in IDLE: the M/WB outputs capture on the next edge.
  - wb_data = address_in, wb_reg_write = control_in[2] & valid_in, wb_valid = valid_in.
  - No stall.
- Misaligned access: a word memop with address_in[1:0] != 0 issues no request.
  - align_fault pulses on the next edge.
  - wb_valid = 1 with wb_reg_write = 0.
  - No stall.
- Aligned memop in IDLE:
  - mem_req is driven combinationally in the same cycle.
  - Byte access: mem_be = 1 << address_in[1:0] and mem_wdata = {4{data_in[7:0]}}.
  - Word access: mem_be = 4'b1111 and mem_wdata = data_in.
  - mem_ack high in the same cycle completes the access with no stall. Otherwise stall is driven high and the FSM goes to WAIT.
- WAIT: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held from the inputs, which upstream keeps stable. stall stays high.
  - On mem_ack: stall drops in that cycle, and M/WB captures on that edge. A load takes wb_data = mem_rdata, or the byte lane address_in[1:0] zero-extended for byte access. A store takes wb_reg_write = 0. The FSM returns to IDLE.
  - Timeout counter: cleared on entry to WAIT and incremented each WAIT cycle. When it reaches TIMEOUT-1 with no ack:
    - bus_err pulses.
    - stall drops.
    - M/WB gets wb_valid = 1 with wb_reg_write = 0.
    - The FSM returns to IDLE.
    - A mem_ack arriving later is ignored.
- While stall is high, M/WB outputs hold their previous values with wb_valid = 0. The bubble is inserted once, on the first stall cycle.
- Reset (asynchronous, mid-transaction included): the FSM goes to IDLE, the counter clears, and all registered outputs go to 0. Combinational mem_req, stall and mem_be are also 0 while reset is low.

## Timing
- Latency from valid_in to wb_valid:
  - 1 cycle for non-memop accesses, misaligned accesses and zero-wait memory.
  - N+1 cycles when mem_ack arrives N cycles after the request.
- No new request is issued in the cycle an ack is consumed. The next EX/M instruction is evaluated on the following cycle.
- Throughput is one instruction per cycle when no waits occur.
- mem_req stays continuously high from issue until the ack cycle or the timeout cycle inclusive.

## Test plan
- ALU op: valid_in=1, control=4'b0100, address_in=0x1234, rgD=5, no stall → next cycle wb_valid=1, wb_data=0x1234, wb_rgD_index=5, wb_reg_write=1.
- Word load with 3-cycle ack delay: address=0x100, rdata=0xDEADBEEF → stall high for 3 cycles, mem_req held; wb_data=0xDEADBEEF one cycle after the ack.
- Byte store: address=0x103, data_in=0xAB → mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1; wb_reg_write=0.
- Byte load at 0x102 with rdata=0x11223344 → wb_data=0x00000022.
- Word load at 0x102 → no mem_req, align_fault pulse, wb_reg_write=0, stall never asserted.
- TIMEOUT=4 with no ack → stall high for exactly 4 cycles, bus_err pulse, FSM returns to IDLE; reset asserted mid-WAIT in a second run → mem_req and stall go to 0 immediately.
